// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if: FIFO pop port and config-write port of the command parser.
interface uart_cmd_parser_if;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        cfg_ready;
    logic        cfg_wr_en;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    modport master (input fifo_dout, fifo_empty, cfg_ready, output fifo_rd_en, cfg_wr_en, cfg_addr, cfg_wdata);
    modport slave (output fifo_dout, fifo_empty, cfg_ready, input fifo_rd_en, cfg_wr_en, cfg_addr, cfg_wdata);
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames FIFO bytes into 7-byte XOR-checked packets and issues one config write per good packet.
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 20000,
    parameter int         CNT_W          = 8
) (
    input  logic             clk_50m,
    input  logic             reset_n,
    uart_cmd_parser_if.master bus,
    output logic [CNT_W-1:0] frame_ok_cnt,
    output logic [CNT_W-1:0] chk_err_cnt,
    output logic [CNT_W-1:0] tmo_err_cnt,
    output logic [CNT_W-1:0] sync_drop_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [1:0] S_REQ    = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_CAP    = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [7:0]       xor_q, xor_d, addr_q, addr_d, cfg_addr_q, cfg_addr_d;
    logic [31:0]      data_q, data_d, cfg_wdata_q, cfg_wdata_d;
    logic             rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [CNT_W-1:0] ok_q, ok_d, chk_q, chk_d, tmo_q, tmo_d, drop_q, drop_d;

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        xor_d       = xor_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_wdata_d = cfg_wdata_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        ok_d        = ok_q;
        chk_d       = chk_q;
        tmo_d       = tmo_q;
        drop_d      = drop_q;
        case (state_q)
            S_REQ: begin
                // expiry takes priority over a byte arriving in the same cycle
                if (idx_q != 3'd0 && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = sat(tmo_q);
                    idx_d   = 3'd0;
                    timer_d = '0;
                end else begin
                    timer_d = (idx_q != 3'd0) ? timer_q + TW'(1) : timer_q;
                    if (!bus.fifo_empty) begin
                        rd_en_d = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: state_d = S_CAP;
            S_CAP: begin
                timer_d = '0;
                state_d = S_REQ;
                if (idx_q == 3'd0) begin
                    idx_d  = (bus.fifo_dout == SYNC_BYTE) ? 3'd1 : 3'd0;
                    drop_d = (bus.fifo_dout == SYNC_BYTE) ? drop_q : sat(drop_q);
                end else if (idx_q == 3'd1) begin
                    addr_d = bus.fifo_dout;
                    xor_d  = bus.fifo_dout;
                    idx_d  = 3'd2;
                end else if (idx_q < 3'd6) begin
                    data_d = {data_q[23:0], bus.fifo_dout};
                    xor_d  = xor_q ^ bus.fifo_dout;
                    idx_d  = idx_q + 3'd1;
                end else if (xor_q == bus.fifo_dout) begin
                    state_d = S_COMMIT;
                end else begin
                    chk_d = sat(chk_q);
                    idx_d = 3'd0;
                end
            end
            default: begin
                if (bus.cfg_ready) begin
                    wr_en_d     = 1'b1;
                    cfg_addr_d  = addr_q;
                    cfg_wdata_d = data_q;
                    ok_d        = sat(ok_q);
                    idx_d       = 3'd0;
                    state_d     = S_REQ;
                end
            end
        endcase
    end

    always_ff @(posedge clk_50m or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_REQ;
            idx_q       <= '0;
            timer_q     <= '0;
            xor_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            ok_q        <= '0;
            chk_q       <= '0;
            tmo_q       <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            xor_q       <= xor_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wdata_q <= cfg_wdata_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            ok_q        <= ok_d;
            chk_q       <= chk_d;
            tmo_q       <= tmo_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.fifo_rd_en = rd_en_q;
    assign bus.cfg_wr_en  = wr_en_q;
    assign bus.cfg_addr   = cfg_addr_q;
    assign bus.cfg_wdata  = cfg_wdata_q;
    assign frame_ok_cnt   = ok_q;
    assign chk_err_cnt    = chk_q;
    assign tmo_err_cnt    = tmo_q;
    assign sync_drop_cnt  = drop_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed frames through a byte-FIFO model, checking writes, counters and pop protocol.
module tb_uart_cmd_parser;
    localparam int T = 20000;

    logic       clk_50m = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] frame_ok_cnt, chk_err_cnt, tmo_err_cnt, sync_drop_cnt;
    logic [7:0] mem [0:4095];
    int         wp = 0, rp = 0;
    int         total = 0, bad = 0;
    int         wr_cnt = 0, pop_cnt = 0, viol = 0;
    logic [7:0] last_addr = '0;
    logic [31:0] last_data = '0;
    logic       prev_rd = 1'b0;
    int         exp_ok = 0, exp_chk = 0, exp_tmo = 0, exp_drop = 0;

    uart_cmd_parser_if bus ();

    uart_cmd_parser dut (
        .clk_50m(clk_50m), .reset_n(reset_n), .bus(bus),
        .frame_ok_cnt(frame_ok_cnt), .chk_err_cnt(chk_err_cnt),
        .tmo_err_cnt(tmo_err_cnt), .sync_drop_cnt(sync_drop_cnt)
    );

    always #10 clk_50m = ~clk_50m;

    assign bus.fifo_empty = (wp == rp);

    always @(posedge clk_50m) begin
        if (bus.fifo_rd_en && rp != wp) begin
            bus.fifo_dout <= mem[rp];
            rp <= rp + 1;
        end
    end

    always @(posedge clk_50m) begin
        if (reset_n) begin
            if (bus.fifo_rd_en) pop_cnt <= pop_cnt + 1;
            if ((bus.fifo_rd_en && (bus.fifo_empty || prev_rd)) || (bus.cfg_wr_en && !bus.cfg_ready)) viol <= viol + 1;
            if (bus.cfg_wr_en) begin
                wr_cnt    <= wr_cnt + 1;
                last_addr <= bus.cfg_addr;
                last_data <= bus.cfg_wdata;
            end
        end
        prev_rd <= bus.fifo_rd_en;
    end

    task automatic push(input logic [7:0] b);
        mem[wp] = b;
        wp = wp + 1;
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] flip);
        push(8'hA5); push(a); push(d[31:24]); push(d[23:16]); push(d[15:8]); push(d[7:0]);
        push(a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0] ^ flip);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        bus.cfg_ready = 1'b1;
        bus.fifo_dout = 8'h00;
        run(3);
        total++;
        if ({bus.fifo_rd_en, bus.cfg_wr_en, bus.cfg_addr, bus.cfg_wdata} !== 42'd0) begin
            bad++; $display("FAIL reset_bus got=%h exp=0", {bus.fifo_rd_en, bus.cfg_wr_en, bus.cfg_addr, bus.cfg_wdata});
        end
        total++;
        if ({frame_ok_cnt, chk_err_cnt, tmo_err_cnt, sync_drop_cnt} !== 32'd0) begin
            bad++; $display("FAIL reset_cnt got=%h exp=0", {frame_ok_cnt, chk_err_cnt, tmo_err_cnt, sync_drop_cnt});
        end
        reset_n = 1'b1;
        run(2);
    endtask

    task automatic test_good_frame;
        int w0 = wr_cnt;
        push_frame(8'h10, 32'h12345678, 8'h00);
        run(60);
        exp_ok++;
        total++; if (wr_cnt !== w0 + 1) begin bad++; $display("FAIL good_wr got=%0d exp=%0d", wr_cnt, w0 + 1); end
        total++; if (last_addr !== 8'h10) begin bad++; $display("FAIL good_addr got=%h exp=10", last_addr); end
        total++; if (last_data !== 32'h12345678) begin bad++; $display("FAIL good_data got=%h exp=12345678", last_data); end
        total++; if (frame_ok_cnt !== exp_ok[7:0]) begin bad++; $display("FAIL good_ok got=%0d exp=%0d", frame_ok_cnt, exp_ok); end
    endtask

    task automatic test_bad_chk;
        int w0 = wr_cnt;
        push_frame(8'h10, 32'h12345678, 8'h01);
        run(60);
        exp_chk++;
        total++; if (wr_cnt !== w0) begin bad++; $display("FAIL badchk_wr got=%0d exp=%0d", wr_cnt, w0); end
        total++; if (chk_err_cnt !== exp_chk[7:0]) begin bad++; $display("FAIL badchk_cnt got=%0d exp=%0d", chk_err_cnt, exp_chk); end
        push_frame(8'h20, 32'hDEADBEEF, 8'h00);
        run(60);
        exp_ok++;
        total++; if (wr_cnt !== w0 + 1) begin bad++; $display("FAIL badchk_next_wr got=%0d exp=%0d", wr_cnt, w0 + 1); end
        total++; if (last_data !== 32'hDEADBEEF) begin bad++; $display("FAIL badchk_next_data got=%h exp=deadbeef", last_data); end
    endtask

    task automatic test_sync_hunt;
        int w0 = wr_cnt;
        push(8'h00); push(8'hFF);
        push_frame(8'h33, 32'hCAFEF00D, 8'h00);
        run(80);
        exp_drop += 2; exp_ok++;
        total++; if (sync_drop_cnt !== exp_drop[7:0]) begin bad++; $display("FAIL hunt_drop got=%0d exp=%0d", sync_drop_cnt, exp_drop); end
        total++; if (wr_cnt !== w0 + 1) begin bad++; $display("FAIL hunt_wr got=%0d exp=%0d", wr_cnt, w0 + 1); end
        total++; if ({last_addr, last_data} !== 40'h33CAFEF00D) begin bad++; $display("FAIL hunt_write got=%h exp=33cafef00d", {last_addr, last_data}); end
    endtask

    task automatic test_sync_as_data;
        int w0 = wr_cnt;
        push_frame(8'hA5, 32'hA5A5A5A5, 8'h00);
        run(60);
        exp_ok++;
        total++; if (wr_cnt !== w0 + 1) begin bad++; $display("FAIL syncdata_wr got=%0d exp=%0d", wr_cnt, w0 + 1); end
        total++; if ({last_addr, last_data} !== 40'hA5A5A5A5A5) begin bad++; $display("FAIL syncdata_write got=%h exp=a5a5a5a5a5", {last_addr, last_data}); end
        total++; if (sync_drop_cnt !== exp_drop[7:0]) begin bad++; $display("FAIL syncdata_drop got=%0d exp=%0d", sync_drop_cnt, exp_drop); end
    endtask

    task automatic test_timeout;
        int n = 0;
        int w0 = wr_cnt;
        push(8'hA5); push(8'h10); push(8'h12);
        for (int i = 0; i < 200 && n < 3; i++) begin
            @(negedge clk_50m);
            if (bus.fifo_rd_en) n++;
        end
        total++; if (n !== 3) begin bad++; $display("FAIL tmo_pops got=%0d exp=3", n); end
        repeat (T + 1) @(posedge clk_50m);
        @(negedge clk_50m);
        total++; if (tmo_err_cnt !== exp_tmo[7:0]) begin bad++; $display("FAIL tmo_early got=%0d exp=%0d", tmo_err_cnt, exp_tmo); end
        @(posedge clk_50m);
        @(negedge clk_50m);
        exp_tmo++;
        total++; if (tmo_err_cnt !== exp_tmo[7:0]) begin bad++; $display("FAIL tmo_fire got=%0d exp=%0d", tmo_err_cnt, exp_tmo); end
        push_frame(8'h55, 32'h0BADF00D, 8'h00);
        run(60);
        exp_ok++;
        total++; if ({last_addr, last_data} !== 40'h550BADF00D || wr_cnt !== w0 + 1) begin
            bad++; $display("FAIL tmo_after got=%h/%0d exp=550badf00d/%0d", {last_addr, last_data}, wr_cnt, w0 + 1);
        end
    endtask

    task automatic test_backpressure;
        int w0 = wr_cnt;
        int p0 = pop_cnt;
        bus.cfg_ready = 1'b0;
        push_frame(8'h44, 32'h01020304, 8'h00);
        push(8'hA5);
        run(500);
        total++; if (wr_cnt !== w0) begin bad++; $display("FAIL bp_stall_wr got=%0d exp=%0d", wr_cnt, w0); end
        total++; if (pop_cnt - p0 !== 7) begin bad++; $display("FAIL bp_pops got=%0d exp=7", pop_cnt - p0); end
        bus.cfg_ready = 1'b1;
        @(posedge clk_50m);
        @(negedge clk_50m);
        total++; if ({bus.cfg_wr_en, bus.cfg_addr, bus.cfg_wdata} !== 41'h1_44_01020304) begin
            bad++; $display("FAIL bp_strobe got=%h exp=14401020304", {bus.cfg_wr_en, bus.cfg_addr, bus.cfg_wdata});
        end
        @(negedge clk_50m);
        total++; if (bus.cfg_wr_en !== 1'b0) begin bad++; $display("FAIL bp_one_cycle got=%b exp=0", bus.cfg_wr_en); end
        run(40);
        exp_ok++;
        total++; if (tmo_err_cnt !== exp_tmo[7:0]) begin bad++; $display("FAIL bp_tmo got=%0d exp=%0d", tmo_err_cnt, exp_tmo); end
        total++; if (frame_ok_cnt !== exp_ok[7:0]) begin bad++; $display("FAIL bp_ok got=%0d exp=%0d", frame_ok_cnt, exp_ok); end
        push(8'h10); push(8'h00); push(8'h00); push(8'h00); push(8'h00); push(8'h10);
        run(60);
        exp_ok++;
    endtask

    task automatic test_reset_midframe;
        int n = 0;
        int w0;
        push(8'hA5); push(8'h10); push(8'h12); push(8'h34);
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(negedge clk_50m);
            if (bus.fifo_rd_en) n++;
        end
        run(5);
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.fifo_rd_en, bus.cfg_wr_en, bus.cfg_addr, bus.cfg_wdata, frame_ok_cnt, chk_err_cnt, tmo_err_cnt, sync_drop_cnt} !== 74'd0) begin
            bad++; $display("FAIL midreset_outs got=%h exp=0", {bus.cfg_addr, bus.cfg_wdata, frame_ok_cnt, chk_err_cnt, tmo_err_cnt, sync_drop_cnt});
        end
        @(negedge clk_50m);
        reset_n = 1'b1;
        exp_ok = 0; exp_chk = 0; exp_tmo = 0; exp_drop = 0;
        run(2);
        w0 = wr_cnt;
        push_frame(8'h66, 32'h89ABCDEF, 8'h00);
        run(60);
        exp_ok++;
        total++; if ({last_addr, last_data} !== 40'h6689ABCDEF || wr_cnt !== w0 + 1) begin
            bad++; $display("FAIL midreset_after got=%h/%0d exp=6689abcdef/%0d", {last_addr, last_data}, wr_cnt, w0 + 1);
        end
        total++; if (frame_ok_cnt !== exp_ok[7:0]) begin bad++; $display("FAIL midreset_ok got=%0d exp=%0d", frame_ok_cnt, exp_ok); end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 300; i++) push_frame(8'h01, 32'h0, 8'h80);
        for (int i = 0; i < 10000 && rp != wp; i++) @(negedge clk_50m);
        total++; if (rp !== wp) begin bad++; $display("FAIL sat_drain got=%0d exp=%0d", rp, wp); end
        run(20);
        total++; if (chk_err_cnt !== 8'd255) begin bad++; $display("FAIL sat_chk got=%0d exp=255", chk_err_cnt); end
        total++; if (frame_ok_cnt !== exp_ok[7:0]) begin bad++; $display("FAIL sat_ok got=%0d exp=%0d", frame_ok_cnt, exp_ok); end
    endtask

    task automatic test_protocol;
        total++; if (viol !== 0) begin bad++; $display("FAIL protocol_viol got=%0d exp=0", viol); end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_bad_chk;
        test_sync_hunt;
        test_sync_as_data;
        test_timeout;
        test_backpressure;
        test_reset_midframe;
        test_saturation;
        test_protocol;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
